me_pixel_ram: RTL
=================

# me_pixel_ram

Synthesizable pixel memory that serves the motion-estimation core (`me`). It sits on the far side of the `me` RAM read port (`en_ram`/`addr`/`amt`).
- Write side: a raster pixel stream loads one current macroblock and one search window.
- Read side: each `en_ram` request returns one current-macroblock row and one barrel-rotated search-window row slice.
- It replaces the behavioural RAM model used in block-level simulation with banked BRAM-inferable storage and a load controller.

## Interface
- `MACRO_DIM`, 16, macroblock edge in pixels.
- `SEARCH_DIM`, 48, search-window edge in pixels.
- `PORT_WIDTH`, `MACRO_DIM+1` (derived, not overridable), number of search-window banks.
- `NSTRIPE`, `ceil(SEARCH_DIM/PORT_WIDTH)` (derived), column stripes per search bank.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  one-cycle pulse; begins a new load.
- `pix_in`  in  8  stream pixel.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts a pixel. A pixel transfers when `pix_valid & pix_ready`.
- `loaded`  out  1  level; both memories are full and the read port is valid.
- `en_ram`  in  1  read request.
- `addr`  in  `$clog2(SEARCH_DIM*NSTRIPE)`  read row address.
- `amt`  in  `$clog2(PORT_WIDTH)`  search rotation, 0..`PORT_WIDTH-1`.
- `pixel_cpr_out[0:MACRO_DIM-1]`  out  8 each  current-macroblock row.
- `pixel_spr_out[0:MACRO_DIM]`  out  8 each  search-window row slice.

## Operation

**Storage**
- Current macroblock: `MACRO_DIM` banks of depth `MACRO_DIM`. Pixel (row r, col c) is stored in bank c, address r.
- Search window: `PORT_WIDTH` banks of depth `SEARCH_DIM*NSTRIPE`. Pixel (r, c) is stored in bank `c % PORT_WIDTH`, address `(c / PORT_WIDTH)*SEARCH_DIM + r`.

**FSM states: IDLE, LOAD_CUR, LOAD_SRCH, READY**
- IDLE: `pix_ready=0`, `loaded=0`. `load_start` moves to LOAD_CUR.
- LOAD_CUR: `pix_ready=1`. Accepts `MACRO_DIM²` pixels in raster order, row-major, tracked by col/row counters. The last accepted pixel moves to LOAD_SRCH.
- LOAD_SRCH: `pix_ready=1`. Accepts `SEARCH_DIM²` pixels in raster order. The last accepted pixel moves to READY.
- READY: `loaded=1`, `pix_ready=0`.
- `load_start` in any state (including mid-load or READY) clears the counters and moves to LOAD_CUR. `loaded` falls the next cycle. Partially written data is simply overwritten.
- Pixels offered while `pix_ready=0` are ignored.

**Read port**
- A read is acted on only when `en_ram=1`.
- Current row: `pixel_cpr_out[l] = cur_bank[l][addr]` for `l < MACRO_DIM`. `addr` must be below `MACRO_DIM`; if it is not, the current-row outputs hold their previous value.
- Search slice, for each lane l:
  - bank `b = (l+amt) % PORT_WIDTH`;
  - bank address = `addr + SEARCH_DIM` if `b < amt`, else `addr`;
  - `pixel_spr_out[l] = srch_bank[b][that address]`.
  - Net effect with `addr = s*SEARCH_DIM + r`: lane l returns search pixel (r, `s*PORT_WIDTH + l + amt`).
- `en_ram=0`: all read outputs hold.
- Reads while `loaded=0` are performed on whatever data is stored. The `me` core must not issue requests before `loaded`.
- Out-of-window requests are not supported: `addr + SEARCH_DIM` beyond bank depth, or column ≥ `SEARCH_DIM`. Lane data is then undefined, but must not corrupt state.
- Loading and reading never happen in the same cycle, because reads are legal only in READY.

## Timing
- **Reset:** state=IDLE, counters=0, `pix_ready=0`, `loaded=0`, all `pixel_*_out=0`. Memory contents are not reset.
- **Write:** a pixel accepted in cycle n is readable from cycle n+1.
- **Full load:** after `load_start` at cycle 0 with `pix_valid` held high, `loaded` rises exactly `MACRO_DIM² + SEARCH_DIM² + 1` cycles later: 2561 at default parameters.
- **Read latency:** 1 cycle. Request sampled at edge n; data is valid after edge n+1 and held until the next accepted request.
- **Back-to-back reads:** one request per cycle is sustained with no bubbles.
- **Rotation mux:** lives on the address/bank-select side before the registers. The output register is the only pipeline stage.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `en_ram=1` → all outputs 0, `pix_ready=0`, `loaded=0`.
- **Full load.**
  - Stimulus: current pixel = `(r*16+c) & 0xFF`, search pixel = `(r*48+c) & 0xFF`, `pix_valid` always high.
  - Response: `pix_ready` high for exactly 2560 cycles, `loaded` rises 2561 cycles after `load_start`.
  - Then read `addr=2`, `amt=0` → `pixel_cpr_out[0]=32`, `pixel_cpr_out[15]=47`, `pixel_spr_out[0..16]=96..112`.
- **Rotation.** `addr=3`, `amt=5` → `pixel_spr_out[0]=149`, `pixel_spr_out[11]=160`, `pixel_spr_out[12]=161`, `pixel_spr_out[16]=165`.
- **Stripe 1.** `addr=48+4`, `amt=16` → lane 0 returns pixel (4, 33) = `(192+33) & 0xFF = 225`.
- **Throttled load.** `pix_valid` toggling 1,0,1,0 → only valid beats counted, `loaded` rises after 2560 accepted pixels. Then `en_ram=0` for 10 cycles → outputs unchanged.
- **Restart.** `load_start` at pixel 100 of LOAD_SRCH → next cycle `loaded=0`, state LOAD_CUR, counters 0. A fresh 2560-pixel load completes correctly with new data.

Source files
------------

// File: rtl/me_pixel_ram_if.sv
// Pixel-stream load port and me-core read port of the pixel RAM.
interface me_pixel_ram_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
);
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NSTRIPE    = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int AW         = $clog2(SEARCH_DIM * NSTRIPE);
  localparam int BW         = $clog2(PORT_WIDTH);

  logic          load_start;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          loaded;
  logic          en_ram;
  logic [AW-1:0] addr;
  logic [BW-1:0] amt;
  logic [7:0]    pixel_cpr_out [0:MACRO_DIM-1];
  logic [7:0]    pixel_spr_out [0:MACRO_DIM];

  modport master (
    output load_start, pix_in, pix_valid, en_ram, addr, amt,
    input  pix_ready, loaded, pixel_cpr_out, pixel_spr_out
  );

  modport slave (
    input  load_start, pix_in, pix_valid, en_ram, addr, amt,
    output pix_ready, loaded, pixel_cpr_out, pixel_spr_out
  );
endinterface

// File: rtl/me_pixel_ram.sv
// Banked current-macroblock / search-window store with raster load controller.
// state       | meaning
// S_IDLE      | nothing loaded, stream stalled
// S_LOAD_CUR  | accepting current macroblock pixels, raster order
// S_LOAD_SRCH | accepting search window pixels, raster order
// S_READY     | both memories full, read port valid
module me_pixel_ram #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input logic           clk_i,
  input logic           rst_i,
  me_pixel_ram_if.slave bus
);
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NSTRIPE    = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int DEPTH      = SEARCH_DIM * NSTRIPE;
  localparam int AW         = $clog2(DEPTH);
  localparam int BW         = $clog2(PORT_WIDTH);
  localparam int CW         = $clog2(SEARCH_DIM);
  localparam int MW         = $clog2(MACRO_DIM);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_CUR, S_LOAD_SRCH, S_READY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [BW-1:0] sbank_q, sbank_d;
  logic [AW-1:0] sbase_q, sbase_d;
  logic          accept;

  logic [7:0] cur_mem  [0:MACRO_DIM-1][0:MACRO_DIM-1];
  logic [7:0] srch_mem [0:PORT_WIDTH-1][0:DEPTH-1];
  logic [7:0] cpr_q    [0:MACRO_DIM-1];
  logic [7:0] spr_q    [0:PORT_WIDTH-1];

  logic [BW-1:0] rd_bank [0:PORT_WIDTH-1];
  logic [AW-1:0] rd_addr [0:PORT_WIDTH-1];
  logic [BW:0]   lane_sum;
  logic [AW:0]   addr_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sbank_q <= '0;
      sbase_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sbank_q <= sbank_d;
      sbase_q <= sbase_d;
    end
  end

  // sbank/sbase track col % PORT_WIDTH and (col / PORT_WIDTH) * SEARCH_DIM without dividers
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    sbank_d       = sbank_q;
    sbase_d       = sbase_q;
    bus.pix_ready = (state_q == S_LOAD_CUR) || (state_q == S_LOAD_SRCH);
    bus.loaded    = (state_q == S_READY);
    accept        = bus.pix_ready && bus.pix_valid;
    if (bus.load_start) begin
      state_d = S_LOAD_CUR;
      col_d   = '0;
      row_d   = '0;
      sbank_d = '0;
      sbase_d = '0;
    end else if (accept && state_q == S_LOAD_CUR) begin
      if (col_q == CW'(MACRO_DIM - 1)) begin
        col_d = '0;
        if (row_q == CW'(MACRO_DIM - 1)) begin
          row_d   = '0;
          state_d = S_LOAD_SRCH;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (accept) begin
      if (col_q == CW'(SEARCH_DIM - 1)) begin
        col_d   = '0;
        sbank_d = '0;
        sbase_d = '0;
        if (row_q == CW'(SEARCH_DIM - 1)) begin
          row_d   = '0;
          state_d = S_READY;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        if (sbank_q == BW'(PORT_WIDTH - 1)) begin
          sbank_d = '0;
          sbase_d = sbase_q + AW'(SEARCH_DIM);
        end else begin
          sbank_d = sbank_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && state_q == S_LOAD_CUR)
      cur_mem[col_q[MW-1:0]][row_q[MW-1:0]] <= bus.pix_in;
    if (accept && state_q == S_LOAD_SRCH)
      srch_mem[sbank_q][sbase_q + AW'(row_q)] <= bus.pix_in;
  end

  // Lanes whose bank wraps below amt read the next stripe; out-of-window picks are clamped
  always_comb begin
    lane_sum = '0;
    addr_sum = '0;
    for (int l = 0; l < PORT_WIDTH; l++) begin
      lane_sum = (BW+1)'(l) + (BW+1)'(bus.amt);
      if (lane_sum >= (BW+1)'(PORT_WIDTH))
        lane_sum = lane_sum - (BW+1)'(PORT_WIDTH);
      rd_bank[l] = (lane_sum < (BW+1)'(PORT_WIDTH)) ? lane_sum[BW-1:0] : '0;
      addr_sum   = (AW+1)'(bus.addr) +
                   ((lane_sum < (BW+1)'(bus.amt)) ? (AW+1)'(SEARCH_DIM) : '0);
      rd_addr[l] = (addr_sum < (AW+1)'(DEPTH)) ? addr_sum[AW-1:0] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < MACRO_DIM; l++) cpr_q[l] <= '0;
      for (int l = 0; l < PORT_WIDTH; l++) spr_q[l] <= '0;
    end else if (bus.en_ram) begin
      if (bus.addr < AW'(MACRO_DIM))
        for (int l = 0; l < MACRO_DIM; l++) cpr_q[l] <= cur_mem[l][bus.addr[MW-1:0]];
      for (int l = 0; l < PORT_WIDTH; l++) spr_q[l] <= srch_mem[rd_bank[l]][rd_addr[l]];
    end
  end

  assign bus.pixel_cpr_out = cpr_q;
  assign bus.pixel_spr_out = spr_q;
endmodule
